// File: rtl/sysid_read_arbiter.sv
// Round-robin arbiter sharing one system-ID read slave between NUM_REQ masters.
// One read in flight; every transaction walks IDLE -> ISSUE -> [WAIT] -> RESP -> IDLE.
module sysid_read_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LATENCY = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_read,
  input  logic [NUM_REQ-1:0] req_address,
  output logic [NUM_REQ-1:0] req_waitrequest,
  output logic [DATA_W-1:0]  req_readdata,
  output logic               sysid_read,
  output logic               sysid_address,
  input  logic [DATA_W-1:0]  sysid_readdata,
  output logic               busy
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     r_last_grant;
  logic [CW-1:0]     r_cnt;
  logic              r_sysid_read;
  logic              r_sysid_address;
  logic [DATA_W-1:0] r_readdata;
  logic              r_busy;

  logic              w_found;
  logic [GW-1:0]     w_sel;
  logic [GW-1:0]     w_idx;

  // First requester found searching upward from last_grant+1, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int unsigned s = 1; s <= NUM_REQ; s++) begin
      w_idx = GW'((32'(r_last_grant) + s) % NUM_REQ);
      if (!w_found && req_read[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  // Only the granted requester, and only in RESP, is released.
  always_comb begin
    req_waitrequest = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_waitrequest[i] = req_read[i] & ~((r_state == S_RESP) && (r_grant == GW'(i)));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_grant         <= '0;
      r_last_grant    <= GW'(NUM_REQ - 1);
      r_cnt           <= '0;
      r_sysid_read    <= 1'b0;
      r_sysid_address <= 1'b0;
      r_readdata      <= '0;
      r_busy          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant         <= w_sel;
            r_sysid_address <= req_address[w_sel];
            r_sysid_read    <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_sysid_read <= 1'b0;
          if (READ_LATENCY == 0) begin
            r_readdata <= sysid_readdata;
            r_state    <= S_RESP;
          end else begin
            r_cnt   <= CW'(READ_LATENCY);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_readdata <= sysid_readdata;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          // Advances even if the requester abandoned its read.
          r_last_grant <= r_grant;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_readdata  = r_readdata;
  assign sysid_read    = r_sysid_read;
  assign sysid_address = r_sysid_address;
  assign busy          = r_busy;

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Bench for sysid_read_arbiter: two instances (latency 0 and 2), a transaction-level
// reference model, directed cases with literal expectations, then randomized traffic.
module tb_sysid_read_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  rd [2];
  logic [3:0]  ad [2];

  logic [3:0]  wr0, wr1;
  logic [31:0] rdata0, rdata1, sd0, sd1;
  logic        sr0, sr1, sa0, sa1, busy0, busy1;

  logic [3:0]  wr_a    [2];
  logic [31:0] rdata_a [2];
  logic        sread_a [2];
  logic        saddr_a [2];
  logic        busy_a  [2];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int served_q[$];
  int served_c[$];

  sysid_read_arbiter #(.NUM_REQ(4), .DATA_W(32), .READ_LATENCY(0)) u_l0 (
    .clock(clock), .reset(reset), .req_read(rd[0]), .req_address(ad[0]),
    .req_waitrequest(wr0), .req_readdata(rdata0), .sysid_read(sr0),
    .sysid_address(sa0), .sysid_readdata(sd0), .busy(busy0));

  sysid_read_arbiter #(.NUM_REQ(4), .DATA_W(32), .READ_LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .req_read(rd[1]), .req_address(ad[1]),
    .req_waitrequest(wr1), .req_readdata(rdata1), .sysid_read(sr1),
    .sysid_address(sa1), .sysid_readdata(sd1), .busy(busy1));

  always_comb begin
    wr_a[0] = wr0;       wr_a[1] = wr1;
    rdata_a[0] = rdata0; rdata_a[1] = rdata1;
    sread_a[0] = sr0;    sread_a[1] = sr1;
    saddr_a[0] = sa0;    saddr_a[1] = sa1;
    busy_a[0] = busy0;   busy_a[1] = busy1;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] val(input logic a);
    return a ? 32'h4C3B_2A19 : 32'h0000_001D;
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  // Slave models: valid data only in the sampling cycle, random junk otherwise.
  logic [31:0] junk;
  logic [1:0]  pv, pa;
  always @(posedge clock) begin
    junk <= $urandom;
    pv   <= {pv[0], sr1};
    pa   <= {pa[0], sa1};
  end
  assign sd0 = sr0 ? val(sa0) : junk;
  assign sd1 = pv[1] ? val(pa[1]) : junk;

  // Reference model: phase counts cycles since grant; response at phase 2+latency.
  int          m_phase [2];
  logic [1:0]  m_win   [2];
  logic [1:0]  m_last  [2];
  logic        m_addr  [2];
  logic [31:0] m_data  [2];

  function automatic logic [1:0] rr(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] j;
    logic       f;
    rr = 2'd0;
    f  = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      j = last + 2'(s);
      if (!f && r[j]) begin
        rr = j;
        f  = 1'b1;
      end
    end
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_phase[k] <= 0;
        m_win[k]   <= 2'd0;
        m_last[k]  <= 2'd3;
        m_addr[k]  <= 1'b0;
        m_data[k]  <= 32'd0;
      end else if (m_phase[k] == 0) begin
        if (|rd[k]) begin
          m_win[k]   <= rr(rd[k], m_last[k]);
          m_addr[k]  <= ad[k][rr(rd[k], m_last[k])];
          m_phase[k] <= 1;
        end
      end else if (m_phase[k] == 2 + lat(k)) begin
        m_last[k]  <= m_win[k];
        m_phase[k] <= 0;
      end else begin
        if (m_phase[k] == 1 + lat(k)) m_data[k] <= val(m_addr[k]);
        m_phase[k] <= m_phase[k] + 1;
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, k, cyc, got, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    logic [3:0] ew;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++)
        ew[i] = rd[k][i] & ~((m_phase[k] == 2 + lat(k)) && (m_win[k] == 2'(i)));
      chk("m_busy",  k, 32'(busy_a[k]),  32'(m_phase[k] != 0));
      chk("m_sread", k, 32'(sread_a[k]), 32'(m_phase[k] == 1));
      chk("m_saddr", k, 32'(saddr_a[k]), 32'(m_addr[k]));
      chk("m_rdata", k, rdata_a[k],      m_data[k]);
      chk("m_wreq",  k, 32'(wr_a[k]),    32'(ew));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic samp;
    @(negedge clock);
  endtask

  // Hold mask reads until each is accepted; log who was served and when.
  task automatic run(input int k, input logic [3:0] mask, input logic [3:0] addr, input int ncyc);
    logic [3:0] acc;
    served_q.delete();
    served_c.delete();
    step;
    rd[k] = mask;
    ad[k] = addr;
    for (int c = 0; c < ncyc; c++) begin
      samp;
      acc = rd[k] & ~wr_a[k];
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          served_q.push_back(i);
          served_c.push_back(c);
          chk("run_data", k, rdata_a[k], val(addr[i]));
        end
      end
      step;
      rd[k] = rd[k] & ~acc;
    end
  endtask

  task automatic chk_served(input string nm, input int k, input int who[4], input int when[4], input int n);
    chk({nm, "_count"}, k, 32'(served_q.size()), 32'(n));
    for (int j = 0; j < n; j++) begin
      if (j < served_q.size()) begin
        chk({nm, "_who"},  k, 32'(served_q[j]), 32'(who[j]));
        chk({nm, "_when"}, k, 32'(served_c[j]), 32'(when[j]));
      end
    end
  endtask

  initial begin
    logic [3:0] acc [2];
    reset = 1'b1;
    rd[0] = 4'b0010; rd[1] = 4'b0000;
    ad[0] = 4'b0000; ad[1] = 4'b0000;
    repeat (2) @(posedge clock);
    samp;
    chk("rst_busy",  0, 32'(busy0), 32'd0);
    chk("rst_sread", 0, 32'(sr0),   32'd0);
    chk("rst_rdata", 0, rdata0,     32'd0);
    chk("rst_wreq_follows_read", 0, 32'(wr0), 32'h2);
    chk("rst_busy",  1, 32'(busy1), 32'd0);
    rd[0] = 4'b0000;
    reset = 1'b0;

    // Case 1: latency 0, requester 2 reads address 1.
    step; rd[0][2] = 1'b1; ad[0][2] = 1'b1;
    samp; chk("c1_wreq_c0", 0, 32'(wr0[2]), 32'd1);
    step; samp;
    chk("c1_sread_c1", 0, 32'(sr0), 32'd1);
    chk("c1_saddr_c1", 0, 32'(sa0), 32'd1);
    step; samp;
    chk("c1_wreq_c2", 0, 32'(wr0[2]), 32'd0);
    chk("c1_data_c2", 0, rdata0, 32'h4C3B_2A19);
    step; rd[0][2] = 1'b0;
    samp; chk("c1_busy_c3", 0, 32'(busy0), 32'd0);

    // Case 2: fresh reset, all four request at once.
    reset = 1'b1; step; reset = 1'b0;
    run(0, 4'hF, 4'b0110, 14);
    chk_served("c2", 0, '{0, 1, 2, 3}, '{2, 5, 8, 11}, 4);

    // Case 3: after requester 1 is served, 0 and 1 together -> 0 first.
    run(0, 4'b0010, 4'b0000, 5);
    chk_served("c3a", 0, '{1, 0, 0, 0}, '{2, 0, 0, 0}, 1);
    run(0, 4'b0011, 4'b0001, 8);
    chk_served("c3b", 0, '{0, 1, 0, 0}, '{2, 5, 0, 0}, 2);

    // Case 4: latency 2, requester 3 reads address 0; a late address change is ignored.
    step; rd[1][3] = 1'b1; ad[1][3] = 1'b0;
    samp; chk("c4_wreq_c0", 1, 32'(wr1[3]), 32'd1);
    step; ad[1][3] = 1'b1;
    samp; chk("c4_sread_c1", 1, 32'(sr1), 32'd1); chk("c4_saddr_c1", 1, 32'(sa1), 32'd0);
    step; samp; chk("c4_sread_c2", 1, 32'(sr1), 32'd0); chk("c4_saddr_c2", 1, 32'(sa1), 32'd0);
    step; samp; chk("c4_saddr_c3", 1, 32'(sa1), 32'd0); chk("c4_wreq_c3", 1, 32'(wr1[3]), 32'd1);
    step; samp; chk("c4_wreq_c4", 1, 32'(wr1[3]), 32'd0); chk("c4_data_c4", 1, rdata1, 32'h0000_001D);
    step; rd[1][3] = 1'b0;

    // Case 5: requester 1 abandons its read during WAIT while 2 is pending.
    served_q.delete(); served_c.delete();
    step; rd[1] = 4'b0110; ad[1] = 4'b0010;
    for (int c = 0; c < 11; c++) begin
      samp;
      acc[1] = rd[1] & ~wr1;
      for (int i = 0; i < 4; i++)
        if (acc[1][i]) begin served_q.push_back(i); served_c.push_back(c); end
      if (c == 4) begin
        chk("c5_wreq2_held", 1, 32'(wr1[2]), 32'd1);
        chk("c5_captured",   1, rdata1, 32'h4C3B_2A19);
      end
      if (c == 9) chk("c5_data2", 1, rdata1, 32'h0000_001D);
      step;
      rd[1] = rd[1] & ~acc[1];
      if (c == 1) rd[1][1] = 1'b0;
    end
    chk_served("c5", 1, '{2, 0, 0, 0}, '{9, 0, 0, 0}, 1);

    // Case 6: async reset during WAIT, then requester 0 has priority again.
    step; rd[1][3] = 1'b1; ad[1][3] = 1'b1;
    step; step;
    #2 reset = 1'b1;
    #1;
    chk("c6_busy",  1, 32'(busy1), 32'd0);
    chk("c6_sread", 1, 32'(sr1),   32'd0);
    chk("c6_saddr", 1, 32'(sa1),   32'd0);
    chk("c6_rdata", 1, rdata1,     32'd0);
    chk("c6_wreq_follows_read", 1, 32'(wr1[3]), 32'd1);
    rd[1][3] = 1'b0;
    step; reset = 1'b0;
    run(1, 4'b1001, 4'b1000, 12);
    chk_served("c6", 1, '{0, 3, 0, 0}, '{4, 9, 0, 0}, 2);

    // Randomized traffic on both instances, with occasional reset pulses.
    for (int it = 0; it < 3000; it++) begin
      samp;
      for (int k = 0; k < 2; k++) acc[k] = rd[k] & ~wr_a[k];
      step;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          if (acc[k][i]) begin
            rd[k][i] = ($urandom_range(0, 3) == 0);
            ad[k][i] = 1'($urandom_range(0, 1));
          end else if (rd[k][i]) begin
            if ($urandom_range(0, 49) == 0) rd[k][i] = 1'b0;
            if ($urandom_range(0, 4) == 0) ad[k][i] = ~ad[k][i];
          end else if ($urandom_range(0, 3) == 0) begin
            rd[k][i] = 1'b1;
            ad[k][i] = 1'($urandom_range(0, 1));
          end
        end
      end
    end
    samp;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sysid_read_arbiter.md
Name: sysid_read_arbiter

Overview:
- Shares one system-ID slave between NUM_REQ processor masters in the multi-CPU SoC.
- The system-ID slave has a 1-bit word address and 32-bit readdata; address 0 is the system ID and address 1 is the build timestamp.
- Each requester sees a basic Avalon-MM read slave with waitrequest.
- Grants are round-robin, one read in flight at a time; the slave's read latency is set by a parameter.

Parameters:
- NUM_REQ, 4, number of requesting masters (2..8).
- DATA_W, 32, readdata width.
- READ_LATENCY, 0, cycles from the ISSUE cycle to the cycle in which sysid_readdata is sampled (0..15; 0 = combinational slave).

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read strobe, held until accepted.
- req_address  in  NUM_REQ  per-requester word address (bit i for requester i).
- req_waitrequest  out  NUM_REQ  per-requester stall.
- req_readdata  out  DATA_W  shared return data, valid for the granted requester when its waitrequest is low and its read is high.
- sysid_read  out  1  read strobe to the system-ID slave.
- sysid_address  out  1  word address to the system-ID slave.
- sysid_readdata  in  DATA_W  data from the system-ID slave.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state IDLE; sysid_read 0; sysid_address 0; req_readdata 0; busy 0.
  - grant index 0; last_grant NUM_REQ-1, so requester 0 has first priority; latency counter 0.
- Combinational waitrequest: req_waitrequest[i] = req_read[i] AND NOT (state==RESP AND grant==i). Idle requesters therefore see 0.
- State IDLE:
  - If any req_read is set, select the first set bit searching upward from last_grant+1 with wrap modulo NUM_REQ.
  - Register grant and the selected requester's address, then go to ISSUE.
  - Otherwise stay in IDLE.
- State ISSUE:
  - sysid_read=1; sysid_address=latched address.
  - If READ_LATENCY==0, capture sysid_readdata into req_readdata and go to RESP.
  - Otherwise load counter=READ_LATENCY and go to WAIT.
- State WAIT:
  - sysid_read=0; sysid_address is held; counter decrements each cycle.
  - In the cycle the counter equals 1, capture sysid_readdata and go to RESP.
- State RESP:
  - The granted requester sees waitrequest low for exactly one cycle with req_readdata valid.
  - last_grant<=grant; go to IDLE.
  - req_readdata holds its value until the next capture.
- Latency: from the first cycle read is high in IDLE to waitrequest low is 2+READ_LATENCY cycles. Back-to-back grants are spaced 3+READ_LATENCY cycles apart, because IDLE is always visited.
- Address is sampled only in IDLE. Changes while waiting are ignored.
- Requester drops read before RESP (protocol violation):
  - The transaction still completes on the slave side and data is captured but not delivered.
  - last_grant still advances.
  - No other requester's waitrequest is affected.
- Simultaneous requests: only round-robin order decides the winner; losers hold waitrequest high.
- Reset asserted mid-transaction:
  - Immediate return to reset values.
  - Any pending read is abandoned, and the requester's waitrequest follows its read input.
- Width rules:
  - grant/last_grant use clog2(NUM_REQ) bits; the counter is 4 bits.
  - Wrap from NUM_REQ-1 to 0 must be correct for non-power-of-2 NUM_REQ.

Test Plan:
- Bench slave model returns 32'h0000_001D at address 0 and 32'h4C3B_2A19 at address 1.
- Case 1: READ_LATENCY=0, requester 2 reads address 1 at cycle 0 -> sysid_read high at cycle 1; req_waitrequest[2] low at cycle 2 with req_readdata=32'h4C3B_2A19; busy low at cycle 3.
- Case 2: all four requesters read simultaneously after reset -> served in order 0,1,2,3, one completion every 3 cycles, each with correct data for its own address.
- Case 3: after requester 1 is served, requesters 0 and 1 request together -> requester 0 is served first, then requester 1.
- Case 4: READ_LATENCY=2, requester 3 reads address 0 -> sysid_address=0 is held ISSUE through WAIT; data 32'h0000_001D is delivered with waitrequest low at cycle 4.
- Case 5: requester 1 drops read during WAIT while requester 2 is pending -> no response pulse to 1; requester 2 is granted next with correct data.
- Case 6: reset pulse during WAIT -> outputs return to reset values asynchronously. After release, a new read from requester 0 completes normally with requester 0 having priority.
